// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// - RV32I funct3 encodings for memory accesses.
// - FSM state encoding.
// - Lane-select helpers that give the bit offset of a byte or halfword lane.
// - The access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic [4:0] byte_shift(input logic [1:0] addr_lo);
    return {addr_lo, 3'b000};
  endfunction

  function automatic logic [4:0] half_shift(input logic [1:0] addr_lo);
    return {addr_lo[1], 4'b0000};
  endfunction

  // The function covers misaligned halfwords and words, reserved encodings,
  // and unsigned variants used with stores.
  function automatic logic access_illegal(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:         bad = 1'b0;
      F3_H:         bad = addr_lo[0];
      F3_W:         bad = (addr_lo != 2'b00);
      F3_BU:        bad = we;
      F3_HU:        bad = we | addr_lo[0];
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side signals of the load/store unit.
// - slave modport: the LSU itself.
// - master modport: the datapath plus memory that surround it.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  busy;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, busy, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wr_en, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, busy, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the load/store unit.
// Ports:
//   cur_word    - word captured from memory
//   addr_lo     - byte address bits [1:0]
//   funct3      - access size / signedness
//   wdata       - store data, low bits used for sub-word stores
//   merged_word - cur_word with the store lane replaced (whole wdata for W)
//   load_data   - selected lane of cur_word, sign- or zero-extended
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] cur_word,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] merged_word,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    merged_word = cur_word;
    case (funct3[1:0])
      2'b00:   merged_word[byte_shift(addr_lo) +: 8]  = wdata[7:0];
      2'b01:   merged_word[half_shift(addr_lo) +: 16] = wdata[15:0];
      default: merged_word = wdata;
    endcase
  end

  always_comb begin
    lane_b = cur_word[byte_shift(addr_lo) +: 8];
    lane_h = cur_word[half_shift(addr_lo) +: 16];
    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      F3_H:    load_data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      default: load_data = cur_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the datapath and a word-wide memory.
// Sub-word stores are done as read-modify-write against the memory.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - request/response and memory signals (slave modport)
//
// state    | meaning
// ST_IDLE  | ready for a request, classify it on accept
// ST_READ  | read the addressed word into word_q
// ST_WRITE | single-cycle full-word write (SW data or merged SB/SH word)
// ST_RESP  | one-cycle response pulse, error or load data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  lsu_state_t            state_q, state_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  err_q;
  logic                  accept_err;
  logic                  resp_active;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] load_data;

  assign accept_err = access_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= accept_err;
      end
      if (state_q == ST_READ) begin
        word_q <= bus.mem_rd_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (accept_err)                               state_d = ST_RESP;
          else if (bus.req_we && bus.req_funct3 == F3_W) state_d = ST_WRITE;
          else                                          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
    .cur_word    (word_q),
    .addr_lo     (addr_q[1:0]),
    .funct3      (f3_q),
    .wdata       (wdata_q),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  // Write strobe and response pulse are gated by reset, so that an
  // in-flight access is dropped in the cycle that reset arrives.
  assign resp_active     = (state_q == ST_RESP) && !reset;
  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wr_en   = (state_q == ST_WRITE) && !err_q && !reset;
  assign bus.mem_wr_data = (state_q == ST_WRITE) ? merged_word : '0;
  assign bus.resp_valid  = resp_active;
  assign bus.resp_err    = resp_active && err_q;
  assign bus.resp_rdata  = (resp_active && !err_q && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));

  // Word-wide memory seen by the DUT; preload port shares the write process.
  logic [31:0] tb_mem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_idx] <= pl_val;
    else if (bus.mem_wr_en) tb_mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
  end
  assign bus.mem_rd_data = tb_mem[bus.mem_addr[7:2]];

  // Reference model state: a plain byte-addressed memory.
  logic [7:0] ref_bytes [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wr_data;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  task automatic set_word(input int idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = idx[5:0];
    pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = val[8*i +: 8];
  endtask

  // Behavioural expectation from the access rules; updates the byte memory for stores.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                       output int lat, output int nwr, output int wr_cyc,
                       output logic [31:0] wr_data);
    int     a, size;
    longint v;
    a = int'(addr[7:0]);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
          (size == 2 && (a % 2) != 0) || (size == 4 && (a % 4) != 0);
    rdata = 0; nwr = 0; wr_cyc = 0; wr_data = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(ref_bytes[a+i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((longint'(1) << (8*size)) - 1);
      rdata = v[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[a+i] = wdata[8*i +: 8];
      wr_data = ref_word(a);
      nwr = 1;
      lat = (size == 4) ? 2 : 3;
      wr_cyc = (size == 4) ? 1 : 2;
    end
  endtask

  // Drives one access and observes it; cycle numbers count from the accept edge.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int lat, output int nwr,
                            output int wr_cyc, output logic [31:0] wr_data,
                            output logic [31:0] wr_addr);
    int k;
    rdata = 0; err = 0; lat = 0; nwr = 0; wr_cyc = 0; wr_data = 0; wr_addr = 0;
    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) check("ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom_range(0, 7));
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.mem_wr_en) begin
        nwr++;
        wr_cyc  = n;
        wr_data = bus.mem_wr_data;
        wr_addr = bus.mem_addr;
      end
      if (bus.resp_valid) begin
        lat   = n;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_all(input string tag, input logic [31:0] addr,
                             input logic [31:0] g_rd, input logic g_err, input int g_lat,
                             input int g_nwr, input int g_wc, input logic [31:0] g_wd,
                             input logic [31:0] g_wa, input logic [31:0] e_rd,
                             input logic e_err, input int e_lat, input int e_nwr,
                             input int e_wc, input logic [31:0] e_wd);
    check({tag, "_err"}, 32'(g_err), 32'(e_err));
    check({tag, "_rdata"}, g_rd, e_rd);
    check({tag, "_latency"}, 32'(g_lat), 32'(e_lat));
    check({tag, "_nwrites"}, 32'(g_nwr), 32'(e_nwr));
    if (e_nwr != 0) begin
      check({tag, "_wr_cycle"}, 32'(g_wc), 32'(e_wc));
      check({tag, "_wr_data"}, g_wd, e_wd);
      check({tag, "_wr_addr"}, g_wa, addr & 32'hFFFF_FFFC);
      check({tag, "_mem_word"}, tb_mem[addr[7:2]], ref_word(int'(addr[7:0])));
    end
  endtask

  task automatic model_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] e_rd, e_wd, g_rd, g_wd, g_wa;
    logic        e_err, g_err;
    int          e_lat, e_nwr, e_wc, g_lat, g_nwr, g_wc;
    model(we, f3, addr, wdata, e_rd, e_err, e_lat, e_nwr, e_wc, e_wd);
    run_access(we, f3, addr, wdata, g_rd, g_err, g_lat, g_nwr, g_wc, g_wd, g_wa);
    compare_all(tag, addr, g_rd, g_err, g_lat, g_nwr, g_wc, g_wd, g_wa,
                e_rd, e_err, e_lat, e_nwr, e_wc, e_wd);
  endtask

  initial begin
    logic [31:0] m_rd, m_wd, g_rd, g_wd, g_wa;
    logic        m_err, g_err;
    int          m_lat, m_nwr, m_wc, g_lat, g_nwr, g_wc;
    int          accepts, busy_low;
    logic [31:0] saved;

    reset = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    set_word(4, 32'h8899AABB);
    set_word(5, 32'h00000000);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_mem_wr_data", bus.mem_wr_data, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b0;

    //         we    f3      addr    wdata          rdata          err  lat wr  wr_data
    vecs[0]  = '{1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0, 32'h0};
    vecs[1]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000088, 1'b0, 2, 0, 32'h0};
    vecs[2]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h00008899, 1'b0, 2, 0, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 2, 0, 32'h0};
    vecs[4]  = '{1'b1, 3'b000, 32'h12, 32'h123456CC, 32'h0,        1'b0, 3, 1, 32'h88CCAABB};
    vecs[5]  = '{1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 3'b010, 32'h14, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
    vecs[8]  = '{1'b1, 3'b010, 32'h16, 32'h55555555, 32'h0,        1'b1, 1, 0, 32'h0};
    vecs[9]  = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h10, 32'h000000EE, 32'h0,        1'b1, 1, 0, 32'h0};
    vecs[11] = '{1'b0, 3'b110, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
    vecs[12] = '{1'b1, 3'b001, 32'h12, 32'hABCD7777, 32'h0,        1'b0, 3, 1, 32'h7777AABB};
    vecs[13] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h7777AABB, 1'b0, 2, 0, 32'h0};
    vecs[14] = '{1'b0, 3'b000, 32'h13, 32'h0,        32'h00000077, 1'b0, 2, 0, 32'h0};
    vecs[15] = '{1'b0, 3'b101, 32'h10, 32'h0,        32'h0000AABB, 1'b0, 2, 0, 32'h0};

    for (int v = 0; v < 16; v++) begin
      model(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata,
            m_rd, m_err, m_lat, m_nwr, m_wc, m_wd);
      run_access(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata,
                 g_rd, g_err, g_lat, g_nwr, g_wc, g_wd, g_wa);
      compare_all($sformatf("vec%0d", v), vecs[v].addr, g_rd, g_err, g_lat, g_nwr, g_wc,
                  g_wd, g_wa, vecs[v].exp_rdata, vecs[v].exp_err, vecs[v].exp_lat,
                  vecs[v].exp_wr, (vecs[v].exp_lat == 2) ? 1 : 2, vecs[v].exp_wr_data);
    end

    // req_valid held high across a whole load: only one accept.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h14; bus.req_wdata = 32'h0;
    accepts = 0; busy_low = 0; g_lat = 0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.req_ready) accepts++;
      if (n > 0 && !bus.busy) busy_low++;
      if (bus.resp_valid) begin
        g_lat = n;
        check("hold_rdata", bus.resp_rdata, ref_word(32'h14));
        bus.req_valid = 1'b0;
        break;
      end
    end
    bus.req_valid = 1'b0;
    check("hold_accepts", 32'(accepts), 32'd1);
    check("hold_busy_low", 32'(busy_low), 32'd0);
    check("hold_latency", 32'(g_lat), 32'd2);

    // Reset arriving in the WRITE cycle of an SH suppresses the write.
    saved = ref_word(32'h10);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h00005555;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rstw_c1_busy", 32'(bus.busy), 32'd1);
    check("rstw_c1_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rstw_c1_addr", bus.mem_addr, 32'h10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstw_c2_wr_en", 32'(bus.mem_wr_en), 32'd0);
    @(negedge clk);
    check("rstw_req_ready", 32'(bus.req_ready), 32'd1);
    check("rstw_busy", 32'(bus.busy), 32'd0);
    check("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstw_resp_err", 32'(bus.resp_err), 32'd0);
    check("rstw_resp_rdata", bus.resp_rdata, 32'd0);
    check("rstw_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rstw_mem_wr_data", bus.mem_wr_data, 32'd0);
    check("rstw_mem_addr", bus.mem_addr, 32'd0);
    check("rstw_mem_word", tb_mem[4], saved);
    reset = 1'b0;
    model_access("rstw_reload", 1'b0, 3'b010, 32'h10, 32'h0);

    // Randomized accesses against the byte-level reference model.
    for (int r = 0; r < 300; r++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFC;
      model_access($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), ra, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
